axi_ready_slice: RTL and testbench



---
 rtl/axi_slice_pkg.sv | 11 +
 rtl/axi_ready_slice.sv | 130 +++++++++++++
 tb/tb_axi_ready_slice.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/axi_slice_pkg.sv
// Shared types for the AXI valid/ready channel slices.
// The state encoding doubles as the held-beat count on occupancy_o.
package axi_slice_pkg;

  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'd0,
    SLICE_BUSY  = 2'd1,
    SLICE_FULL  = 2'd2
  } slice_state_e;

endpackage : axi_slice_pkg

// File: rtl/axi_ready_slice.sv
// Backward-path register slice: a 2-entry skid buffer whose ready_o is a flop,
// cutting the ready_i -> ready_o combinational path at full throughput.
module axi_ready_slice
  import axi_slice_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter bit          PASSTHROUGH = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            occupancy_o
);

  if (DATA_WIDTH < 32'd1) begin : g_bad_width
    $error("axi_ready_slice: DATA_WIDTH must be at least 1");
  end

  if (PASSTHROUGH) begin : g_wires
    logic w_unused;

    assign w_unused    = ^{clk_i, rst_i, flush_i};
    assign valid_o     = valid_i;
    assign ready_o     = ready_i;
    assign data_o      = data_i;
    assign occupancy_o = 2'd0;

  end else begin : g_skid
    slice_state_e          r_state;
    slice_state_e          w_state_nxt;
    logic                  r_ready;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  w_in;
    logic                  w_out;
    logic                  w_load_main;
    logic                  w_main_from_skid;
    logic                  w_load_skid;

    assign w_in  = valid_i & r_ready;
    assign w_out = r_valid & ready_i;

    // Next state and register load enables; flush drops held and incoming beats.
    always_comb begin
      w_state_nxt      = r_state;
      w_load_main      = 1'b0;
      w_main_from_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush_i) begin
        w_state_nxt = SLICE_EMPTY;
      end else begin
        case (r_state)
          SLICE_EMPTY: begin
            if (w_in) begin
              w_load_main = 1'b1;
              w_state_nxt = SLICE_BUSY;
            end else begin
              w_state_nxt = SLICE_EMPTY;
            end
          end
          SLICE_BUSY: begin
            if (w_in && w_out) begin
              w_load_main = 1'b1;
            end else if (w_in) begin
              w_load_skid = 1'b1;
              w_state_nxt = SLICE_FULL;
            end else if (w_out) begin
              w_state_nxt = SLICE_EMPTY;
            end else begin
              w_state_nxt = SLICE_BUSY;
            end
          end
          SLICE_FULL: begin
            // Skid beat is always younger, so it only ever moves into main.
            if (w_out) begin
              w_load_main      = 1'b1;
              w_main_from_skid = 1'b1;
              w_state_nxt      = SLICE_BUSY;
            end else begin
              w_state_nxt = SLICE_FULL;
            end
          end
          default: begin
            w_state_nxt = SLICE_EMPTY;
          end
        endcase
      end
    end

    // State, handshake flags and payload registers.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= SLICE_EMPTY;
        r_ready <= 1'b1;
        r_valid <= 1'b0;
        r_main  <= '0;
        r_skid  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_ready <= (w_state_nxt != SLICE_FULL);
        r_valid <= (w_state_nxt != SLICE_EMPTY);
        if (w_load_main) begin
          r_main <= w_main_from_skid ? r_skid : data_i;
        end
        if (w_load_skid) begin
          r_skid <= data_i;
        end
      end
    end

    assign ready_o     = r_ready;
    assign valid_o     = r_valid;
    assign data_o      = r_main;
    assign occupancy_o = r_state;

    // A stalled beat must hold both valid and payload into the next cycle.
    a_stall_stable : assert property (@(posedge clk_i)
      (!rst_i && !flush_i && r_valid && !ready_i) |=> (r_valid && $stable(r_main)));

    a_occ_range : assert property (@(posedge clk_i) (occupancy_o != 2'd3));
  end

endmodule : axi_ready_slice

// File: tb/tb_axi_ready_slice.sv
// Randomized and directed bench for axi_ready_slice against a queue-based
// reference model; a second instance covers the pass-through build.
module tb_axi_ready_slice;

  logic        clk;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_i;
  logic [31:0] data_i;

  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic [1:0]  occupancy_o;

  logic        pt_ready_o;
  logic        pt_valid_o;
  logic [31:0] pt_data_o;
  logic [1:0]  pt_occupancy_o;

  int          n_checks;
  int          n_errors;

  logic [31:0] q[$];
  bit          model_live;
  bit          expect_zero_data;
  bit          accepted;

  axi_ready_slice #(.DATA_WIDTH(32), .PASSTHROUGH(1'b0)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .occupancy_o(occupancy_o)
  );

  axi_ready_slice #(.DATA_WIDTH(32), .PASSTHROUGH(1'b1)) u_pt (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (pt_ready_o),
    .data_i     (data_i),
    .valid_o    (pt_valid_o),
    .ready_i    (ready_i),
    .data_o     (pt_data_o),
    .occupancy_o(pt_occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs, advance the model.
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      input logic f, input logic rs);
    int sz;
    @(negedge clk);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    rst_i   = rs;
    #1;
    check_eq("pt_valid", {31'd0, pt_valid_o}, {31'd0, v});
    check_eq("pt_ready", {31'd0, pt_ready_o}, {31'd0, r});
    check_eq("pt_data", pt_data_o, d);
    check_eq("pt_occ", {30'd0, pt_occupancy_o}, 32'd0);
    accepted = 1'b0;
    if (model_live) begin
      sz = q.size();
      check_eq("occupancy", {30'd0, occupancy_o}, sz);
      check_eq("ready_o", {31'd0, ready_o}, {31'd0, (sz < 2)});
      check_eq("valid_o", {31'd0, valid_o}, {31'd0, (sz > 0)});
      if (sz > 0) begin
        check_eq("data_o", data_o, q[0]);
      end else if (expect_zero_data) begin
        check_eq("rst_data", data_o, 32'd0);
      end
      expect_zero_data = 1'b0;
      if (!rs && !f) begin
        if (sz > 0 && r) begin
          void'(q.pop_front());
        end
        if (v && sz < 2) begin
          q.push_back(d);
          accepted = 1'b1;
        end
      end else begin
        q.delete();
      end
    end
    if (rs) begin
      q.delete();
      model_live       = 1'b1;
      expect_zero_data = 1'b1;
    end
    @(posedge clk);
  endtask

  // Offer one beat until accepted or the try budget runs out.
  task automatic send(input logic [31:0] d, input logic r, input int tries);
    int n;
    n = 0;
    do begin
      step(1'b1, d, r, 1'b0, 1'b0);
      n++;
    end while (!accepted && n < tries);
  endtask

  initial begin
    logic [31:0] src;
    bit          rv;
    clk              = 1'b0;
    rst_i            = 1'b1;
    flush_i          = 1'b0;
    valid_i          = 1'b0;
    ready_i          = 1'b0;
    data_i           = 32'd0;
    n_checks         = 0;
    n_errors         = 0;
    model_live       = 1'b0;
    expect_zero_data = 1'b0;

    // Reset held for two cycles, then an idle cycle observes the reset state.
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Streaming with the sink always ready.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      check_eq("stream_accept", {31'd0, accepted}, 32'd1);
    end
    repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Backpressure: two beats fill the slice, the third waits upstream.
    send(32'hA, 1'b0, 4);
    send(32'hB, 1'b0, 4);
    send(32'hC, 1'b0, 3);
    check_eq("bp_held", {31'd0, accepted}, 32'd0);
    check_eq("bp_occ", {30'd0, occupancy_o}, 32'd2);
    check_eq("bp_ready", {31'd0, ready_o}, 32'd0);
    send(32'hC, 1'b1, 4);
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Flush while full, with a beat offered in the same cycle.
    send(32'h11, 1'b0, 4);
    send(32'h22, 1'b0, 4);
    step(1'b1, 32'hD, 1'b0, 1'b1, 1'b0);
    #2;
    check_eq("flush_occ", {30'd0, occupancy_o}, 32'd0);
    check_eq("flush_valid", {31'd0, valid_o}, 32'd0);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset.
    src = $urandom;
    for (int i = 0; i < 10000; i++) begin
      rv = ($urandom_range(0, 9) < 7);
      step(rv, src, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 999) == 0));
      if (accepted) src = $urandom;
    end
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_axi_ready_slice
